// File: rtl/aemb2_dwb_pkg.sv
// Shared definitions for the AEMB2 data-bus SRAM responder: FSM encoding,
// byte-lane indices (big-endian, byte offset 0 on dat[31:24]) and counter width.
package aemb2_dwb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } dwb_state_e;

    localparam int unsigned LANE_B0 = 3;
    localparam int unsigned LANE_B1 = 2;
    localparam int unsigned LANE_B2 = 1;
    localparam int unsigned LANE_B3 = 0;

    localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/aemb2_dwb_sram_if.sv
// Wishbone data-bus signal bundle between the AEMB2 initiator (master) and
// the SRAM responder (slave).
interface aemb2_dwb_sram_if #(
    parameter int unsigned AEMB_DWB = 32
);
    logic [AEMB_DWB-1:2] dwb_adr_i;
    logic [3:0]          dwb_sel_i;
    logic                dwb_stb_i;
    logic                dwb_cyc_i;
    logic                dwb_wre_i;
    logic                dwb_tag_i;
    logic [31:0]         dwb_dat_i;
    logic [31:0]         dwb_dat_o;
    logic                dwb_ack_o;

    modport master (
        output dwb_adr_i, dwb_sel_i, dwb_stb_i, dwb_cyc_i, dwb_wre_i, dwb_tag_i, dwb_dat_i,
        input  dwb_dat_o, dwb_ack_o
    );

    modport slave (
        input  dwb_adr_i, dwb_sel_i, dwb_stb_i, dwb_cyc_i, dwb_wre_i, dwb_tag_i, dwb_dat_i,
        output dwb_dat_o, dwb_ack_o
    );
endinterface

// File: rtl/aemb2_dwb_bram.sv
// Single-port 2**AW x 32 RAM with four byte write enables and a registered
// read port; the read register clears on reset, the array does not.
module aemb2_dwb_bram #(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdat_i,
    output logic [31:0]   rdat_o
);
    localparam int unsigned DEPTH = 1 << AW;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdat_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdat_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdat_q <= '0;
        end else if (rd_en_i) begin
            rdat_q <= mem_q[addr_i];
        end
    end

    assign rdat_o = rdat_q;

endmodule

// File: rtl/aemb2_dwb_sram.sv
// AEMB2 data-bus SRAM responder with registered single-cycle ack.
// Define AEMB2_DWB_WAIT_EN to insert DWB_WAIT wait cycles with cyc-abort.
module aemb2_dwb_sram
    import aemb2_dwb_pkg::*;
#(
    parameter int unsigned AEMB_DWB = 32,
    parameter int unsigned DWB_AW   = 10,
    parameter int unsigned DWB_WAIT = 2
) (
    input logic              gclk,
    input logic              grst,
    aemb2_dwb_sram_if.slave  dwb
);
    dwb_state_e state_q, state_d;
    logic       ack_q;
    logic       req_c;
    logic       commit_c;
    logic       rd_en_c;
    logic [3:0] we_c;
    logic       unused_c;

`ifdef AEMB2_DWB_WAIT_EN
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(DWB_WAIT - 1);
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign req_c = dwb.dwb_cyc_i & dwb.dwb_stb_i;

    // Next-state logic; commit_c marks the edge that writes the array or captures read data.
    always_comb begin
        state_d  = state_q;
        commit_c = 1'b0;
`ifdef AEMB2_DWB_WAIT_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_c) begin
`ifdef AEMB2_DWB_WAIT_EN
                    if (DWB_WAIT == 0) begin
                        commit_c = 1'b1;
                        state_d  = ACK;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = WAIT;
                    end
`else
                    commit_c = 1'b1;
                    state_d  = ACK;
`endif
                end
            end
            WAIT: begin
`ifdef AEMB2_DWB_WAIT_EN
                if (!dwb.dwb_cyc_i) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    commit_c = 1'b1;
                    state_d  = ACK;
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end
`else
                state_d = IDLE;
`endif
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
`ifdef AEMB2_DWB_WAIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ack_q   <= (state_d == ACK);
`ifdef AEMB2_DWB_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Reset on the commit edge discards the access.
    assign rd_en_c = commit_c & ~dwb.dwb_wre_i & ~grst;
    assign we_c    = {4{commit_c & dwb.dwb_wre_i & ~grst}} & dwb.dwb_sel_i;

    aemb2_dwb_bram #(
        .AW (DWB_AW)
    ) u_bram (
        .clk     (gclk),
        .rst     (grst),
        .rd_en_i (rd_en_c),
        .we_i    (we_c),
        .addr_i  (dwb.dwb_adr_i[DWB_AW+1:2]),
        .wdat_i  (dwb.dwb_dat_i),
        .rdat_o  (dwb.dwb_dat_o)
    );

    assign dwb.dwb_ack_o = ack_q;

    // Tag and upper address bits are accepted but have no effect (array aliases).
    assign unused_c = ^{dwb.dwb_tag_i, dwb.dwb_adr_i[AEMB_DWB-1:DWB_AW+2], 4'(DWB_WAIT)};

endmodule

// File: tb/tb_aemb2_dwb_sram.sv
// Scoreboard bench for aemb2_dwb_sram: driver queues expected dat_o per transfer,
// a negedge monitor pops and compares on every ack.
module tb_aemb2_dwb_sram;
    import aemb2_dwb_pkg::*;

    localparam int unsigned AEMB_DWB = 32;
    localparam int unsigned DWB_AW   = 10;
    localparam int unsigned DWB_WAIT = 2;
`ifdef AEMB2_DWB_WAIT_EN
    localparam int LAT    = 1 + DWB_WAIT;
    localparam int N_HELD = 1;
`else
    localparam int LAT    = 1;
    localparam int N_HELD = 3;
`endif

    typedef struct {
        logic        chk;
        logic [31:0] dat;
    } exp_t;

    logic gclk;
    logic grst;
    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];
    logic [31:0] last_exp;
    logic        last_chk;
    logic        prev_ack;

    aemb2_dwb_sram_if #(.AEMB_DWB(AEMB_DWB)) dwb ();

    aemb2_dwb_sram #(
        .AEMB_DWB (AEMB_DWB),
        .DWB_AW   (DWB_AW),
        .DWB_WAIT (DWB_WAIT)
    ) dut (
        .gclk (gclk),
        .grst (grst),
        .dwb  (dwb)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every ack must match the oldest expectation; acks never back-to-back.
    always @(negedge gclk) begin
        if (dwb.dwb_ack_o === 1'b1) begin
            check("ack_not_consecutive", 32'(prev_ack), 32'h0);
            if (sb_q.size() == 0) begin
                check("unexpected_ack", 32'h1, 32'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.chk) check("sb_dat_o", dwb.dwb_dat_o, e.dat);
            end
        end
        prev_ack = (dwb.dwb_ack_o === 1'b1);
    end

    task automatic idle_bus();
        dwb.dwb_cyc_i = 1'b0;
        dwb.dwb_stb_i = 1'b0;
        dwb.dwb_wre_i = 1'b0;
        dwb.dwb_sel_i = 4'h0;
        dwb.dwb_dat_i = 32'h0;
    endtask

    task automatic drive(input logic wre, input logic [29:0] adr, input logic [3:0] sel,
                         input logic [31:0] wdat);
        dwb.dwb_adr_i = adr;
        dwb.dwb_sel_i = sel;
        dwb.dwb_wre_i = wre;
        dwb.dwb_dat_i = wdat;
        dwb.dwb_tag_i = adr[0];
        dwb.dwb_cyc_i = 1'b1;
        dwb.dwb_stb_i = 1'b1;
    endtask

    // One complete transfer; a read expects rexp on dat_o, a write expects dat_o unchanged.
    task automatic xfer(input string nm, input logic wre, input logic [29:0] adr,
                        input logic [3:0] sel, input logic [31:0] wdat,
                        input logic [31:0] rexp, input logic rchk);
        int  lat;
        logic got;
        @(posedge gclk); #1;
        if (wre) begin
            sb_q.push_back('{chk: last_chk, dat: last_exp});
        end else begin
            sb_q.push_back('{chk: rchk, dat: rexp});
            last_exp = rexp;
            last_chk = rchk;
        end
        drive(wre, adr, sel, wdat);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge gclk); #1;
            lat++;
            if (dwb.dwb_ack_o === 1'b1) got = 1'b1;
        end
        if (!got) lat = -1;
        check({nm, "_latency"}, 32'(lat), 32'(LAT));
        idle_bus();
    endtask

    initial begin
        int acks;
        n_tests  = 0;
        n_fail   = 0;
        last_exp = 32'h0;
        last_chk = 1'b0;
        prev_ack = 1'b0;
        dwb.dwb_adr_i = '0;
        dwb.dwb_tag_i = 1'b0;
        idle_bus();

        grst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge gclk); #1;
            check("rst_ack", 32'(dwb.dwb_ack_o), 32'h0);
            check("rst_dat_o", dwb.dwb_dat_o, 32'h0);
        end
        grst = 1'b0;

        xfer("rd_stale_10", 1'b0, 30'h10, 4'hF, 32'h0, 32'h0, 1'b0);

        xfer("wr_full_5", 1'b1, 30'h5, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
        xfer("rd_full_5", 1'b0, 30'h5, 4'h0, 32'h0, 32'hDEADBEEF, 1'b1);

        xfer("wr_sel8", 1'b1, 30'h5, 4'h8, 32'h11223344, 32'h0, 1'b0);
        xfer("rd_sel8", 1'b0, 30'h5, 4'hF, 32'h0, 32'h11ADBEEF, 1'b1);
        xfer("wr_sel3", 1'b1, 30'h5, 4'h3, 32'h11223344, 32'h0, 1'b0);
        xfer("rd_sel3", 1'b0, 30'h5, 4'h1, 32'h0, 32'h11AD3344, 1'b1);
        xfer("wr_sel0", 1'b1, 30'h5, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0);
        xfer("rd_sel0", 1'b0, 30'h5, 4'hF, 32'h0, 32'h11AD3344, 1'b1);

        // Strobe held for six edges on a single read
        @(posedge gclk); #1;
        for (int i = 0; i < N_HELD; i++) sb_q.push_back('{chk: 1'b1, dat: 32'h11AD3344});
        drive(1'b0, 30'h5, 4'hF, 32'h0);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge gclk); #1;
            if (dwb.dwb_ack_o === 1'b1) acks++;
        end
        idle_bus();
        check("held_stb_acks", 32'(acks), 32'(N_HELD));
        last_exp = 32'h11AD3344;
        last_chk = 1'b1;

        xfer("wr_alias_405", 1'b1, 30'h405, 4'hF, 32'h0000CAFE, 32'h0, 1'b0);
        xfer("rd_alias_005", 1'b0, 30'h005, 4'hF, 32'h0, 32'h0000CAFE, 1'b1);
        xfer("rd_alias_c05", 1'b0, 30'hC05, 4'hF, 32'h0, 32'h0000CAFE, 1'b1);

`ifdef AEMB2_DWB_WAIT_EN
        xfer("wr_w7", 1'b1, 30'h7, 4'hF, 32'h0000A5A5, 32'h0, 1'b0);
        // cyc dropped in WAIT: no ack, no write
        @(posedge gclk); #1;
        drive(1'b1, 30'h7, 4'hF, 32'h55555555);
        @(posedge gclk); #1;
        idle_bus();
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge gclk); #1;
            if (dwb.dwb_ack_o === 1'b1) acks++;
        end
        check("abort_no_ack", 32'(acks), 32'h0);
        xfer("rd_after_abort", 1'b0, 30'h7, 4'hF, 32'h0, 32'h0000A5A5, 1'b1);
        // reset in WAIT: no write, read register cleared
        @(posedge gclk); #1;
        drive(1'b1, 30'h7, 4'hF, 32'h66666666);
        @(posedge gclk); #1;
        grst = 1'b1;
        @(posedge gclk); #1;
        grst = 1'b0;
        idle_bus();
        check("rst_wait_dat_o", dwb.dwb_dat_o, 32'h0);
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge gclk); #1;
            if (dwb.dwb_ack_o === 1'b1) acks++;
        end
        check("rst_wait_no_ack", 32'(acks), 32'h0);
        last_exp = 32'h0;
        last_chk = 1'b1;
        xfer("rd_after_rst", 1'b0, 30'h7, 4'hF, 32'h0, 32'h0000A5A5, 1'b1);
`endif

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge gclk);
        repeat (3) @(posedge gclk);
        check("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
